// File: rtl/otp_ctrl_pkg.sv
// Shared widths, command/state encodings and helpers for the OTP macro arbiter.
// Consumers: otp_ctrl_owner_fifo, otp_ctrl_macro_arb.
package otp_ctrl_pkg;

  localparam int OtpCmdWidth      = 3;
  localparam int OtpErrWidth      = 3;
  localparam int OtpSizeWidth     = 2;
  localparam int OtpIfWidth       = 16;
  localparam int OtpAddrWidth     = 11;
  localparam int ScrmblBlockWidth = 64;

  localparam int LciAgentIdx = 0;

  typedef enum logic [OtpCmdWidth-1:0] {
    Read     = 3'b000,
    Write    = 3'b001,
    ReadRaw  = 3'b010,
    WriteRaw = 3'b011,
    Init     = 3'b111
  } cmd_e;

  // Pairwise Hamming distance >= 3 so a single flipped bit never aliases a legal state.
  typedef enum logic [4:0] {
    ArbSt   = 5'b01101,
    HoldSt  = 5'b10110,
    ErrorSt = 5'b11011
  } arb_state_e;

  function automatic int vbits(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/otp_ctrl_macro_arb_chk.sv
// Protocol checker: a latched requester must keep its request up until granted.
module otp_ctrl_macro_arb_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic hold_i,
  input logic held_req_i
);

  held_req_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    hold_i |-> held_req_i);

endmodule

// File: rtl/otp_ctrl_owner_fifo.sv
// In-order FIFO of agent IDs that own the accepted-but-unanswered macro commands.
module otp_ctrl_owner_fifo
  import otp_ctrl_pkg::*;
#(
  parameter  int Depth  = 2,
  parameter  int Width  = 2,
  localparam int DepthW = vbits(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [Width-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [Width-1:0]  rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [DepthW-1:0] depth_o
);

  localparam int PtrW = vbits(Depth);

  logic [Width-1:0]  mem_q [Depth];
  logic [Width-1:0]  mem_d [Depth];
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DepthW-1:0] cnt_q, cnt_d;
  logic              do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_incr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == DepthW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign depth_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d        = ptr_incr(wptr_q);
    end else begin
      wptr_d = wptr_q;
    end
    rptr_d = do_pop ? ptr_incr(rptr_q) : rptr_q;
    cnt_d  = cnt_q + DepthW'(do_push) - DepthW'(do_pop);
  end

  // FIFO state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/otp_ctrl_macro_arb.sv
// Round-robin arbiter of agent command ports onto the single OTP macro port, with in-order
// response routing. Optional macro OTP_CTRL_ARB_AGENT0_PRIO_EN gives agent 0 absolute priority.
module otp_ctrl_macro_arb
  import otp_ctrl_pkg::*;
#(
  parameter int NumAgents      = 4,
  parameter int MaxOutstanding = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumAgents-1:0]                  agent_req_i,
  input  logic [NumAgents-1:0][OtpCmdWidth-1:0]  agent_cmd_i,
  input  logic [NumAgents-1:0][OtpSizeWidth-1:0] agent_size_i,
  input  logic [NumAgents-1:0][OtpIfWidth-1:0]   agent_wdata_i,
  input  logic [NumAgents-1:0][OtpAddrWidth-1:0] agent_addr_i,
  output logic [NumAgents-1:0]                  agent_gnt_o,
  output logic [NumAgents-1:0]                  agent_rvalid_o,
  output logic [ScrmblBlockWidth-1:0]           agent_rdata_o,
  output logic [OtpErrWidth-1:0]                agent_err_o,
  output logic                                  otp_req_o,
  output logic [OtpCmdWidth-1:0]                otp_cmd_o,
  output logic [OtpSizeWidth-1:0]               otp_size_o,
  output logic [OtpIfWidth-1:0]                 otp_wdata_o,
  output logic [OtpAddrWidth-1:0]               otp_addr_o,
  input  logic                                  otp_gnt_i,
  input  logic                                  otp_rvalid_i,
  input  logic [ScrmblBlockWidth-1:0]           otp_rdata_i,
  input  logic [OtpErrWidth-1:0]                otp_err_i,
  output logic                                  arb_err_o,
  output logic                                  idle_o
);

  localparam int IdW  = vbits(NumAgents);
  localparam int CntW = vbits(MaxOutstanding + 1);

  arb_state_e      state_q, state_d;
  logic [IdW-1:0]  ptr_q, ptr_d, held_q, held_d;
  logic [IdW-1:0]  rr_win, sel, head_id;
  logic [CntW-1:0] fifo_depth;
  logic            fifo_full, fifo_empty;
  logic            any_req, otp_req, push, pop, resp_en, fsm_err, stray_rsp;

  function automatic logic [IdW-1:0] next_ptr(input logic [IdW-1:0] win);
    return (win == IdW'(NumAgents - 1)) ? '0 : win + IdW'(1);
  endfunction

  assign any_req = |agent_req_i;

  // Winner: lowest requester at or above the pointer, else lowest requester overall (wrap).
  always_comb begin
    rr_win = '0;
    for (int i = NumAgents - 1; i >= 0; i--) begin
      rr_win = agent_req_i[i] ? IdW'(i) : rr_win;
    end
    for (int i = NumAgents - 1; i >= 0; i--) begin
      rr_win = (agent_req_i[i] && (IdW'(i) >= ptr_q)) ? IdW'(i) : rr_win;
    end
`ifdef OTP_CTRL_ARB_AGENT0_PRIO_EN
    rr_win = agent_req_i[LciAgentIdx] ? IdW'(LciAgentIdx) : rr_win;
`else
    rr_win = rr_win;
`endif
  end

  // Arbitration FSM: next state, pointer/latch update and macro request.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    held_d  = held_q;
    sel     = rr_win;
    otp_req = 1'b0;
    push    = 1'b0;
    fsm_err = 1'b0;
    case (state_q)
      ArbSt: begin
        if (!fifo_full && any_req) begin
          otp_req = 1'b1;
          if (otp_gnt_i) begin
            push  = 1'b1;
            ptr_d = next_ptr(rr_win);
          end else begin
            held_d  = rr_win;
            state_d = HoldSt;
          end
        end else begin
          otp_req = 1'b0;
        end
      end
      HoldSt: begin
        sel     = held_q;
        otp_req = 1'b1;
        if (otp_gnt_i) begin
          push    = 1'b1;
          ptr_d   = next_ptr(held_q);
          state_d = ArbSt;
        end else begin
          state_d = HoldSt;
        end
      end
      ErrorSt: begin
        fsm_err = 1'b1;
        state_d = ErrorSt;
      end
      default: begin
        fsm_err = 1'b1;
        state_d = ErrorSt;
      end
    endcase
  end

  // Responses are only routed from a legal operating state.
  assign resp_en   = (state_q == ArbSt) || (state_q == HoldSt);
  assign pop       = resp_en && otp_rvalid_i && !fifo_empty;
  assign stray_rsp = resp_en && otp_rvalid_i && fifo_empty;

  assign agent_gnt_o    = push ? (NumAgents'(1) << sel) : '0;
  assign agent_rvalid_o = pop ? (NumAgents'(1) << head_id) : '0;
  assign agent_rdata_o  = otp_rdata_i;
  assign agent_err_o    = otp_err_i;

  assign otp_req_o   = otp_req;
  assign otp_cmd_o   = otp_req ? agent_cmd_i[sel] : OtpCmdWidth'(Read);
  assign otp_size_o  = otp_req ? agent_size_i[sel] : '0;
  assign otp_wdata_o = otp_req ? agent_wdata_i[sel] : '0;
  assign otp_addr_o  = otp_req ? agent_addr_i[sel] : '0;

  assign arb_err_o = fsm_err || stray_rsp;
  assign idle_o    = !any_req && (fifo_depth == '0);

  // FSM state, round-robin pointer and held winner.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ArbSt;
      ptr_q   <= '0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      held_q  <= held_d;
    end
  end

  otp_ctrl_owner_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdW)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (sel),
    .pop_i   (pop),
    .rdata_o (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .depth_o (fifo_depth)
  );

  otp_ctrl_macro_arb_chk u_chk (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .hold_i     (state_q == HoldSt),
    .held_req_i (agent_req_i[held_q])
  );

endmodule

// File: tb/tb_otp_ctrl_macro_arb.sv
// Scoreboard bench for otp_ctrl_macro_arb: expected grants/responses are queued with their cycle.
module tb_otp_ctrl_macro_arb;
  import otp_ctrl_pkg::*;

`ifdef OTP_CTRL_ARB_AGENT0_PRIO_EN
  localparam bit Prio = 1'b1;
`else
  localparam bit Prio = 1'b0;
`endif

  logic                                  clk = 1'b0;
  logic                                  rst_ni;
  logic [3:0]                            agent_req;
  logic [3:0][OtpCmdWidth-1:0]           agent_cmd;
  logic [3:0][OtpSizeWidth-1:0]          agent_size;
  logic [3:0][OtpIfWidth-1:0]            agent_wdata;
  logic [3:0][OtpAddrWidth-1:0]          agent_addr;
  logic [3:0]                            agent_gnt_o, agent_rvalid_o;
  logic [ScrmblBlockWidth-1:0]           agent_rdata_o;
  logic [OtpErrWidth-1:0]                agent_err_o;
  logic                                  otp_req_o;
  logic [OtpCmdWidth-1:0]                otp_cmd_o;
  logic [OtpSizeWidth-1:0]               otp_size_o;
  logic [OtpIfWidth-1:0]                 otp_wdata_o;
  logic [OtpAddrWidth-1:0]               otp_addr_o;
  logic                                  otp_gnt, otp_rvalid;
  logic [ScrmblBlockWidth-1:0]           otp_rdata;
  logic [OtpErrWidth-1:0]                otp_err;
  logic                                  arb_err_o, idle_o;

  typedef struct {
    int          agent;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [OtpAddrWidth-1:0] addr_tbl [4] = '{11'h010, 11'h121, 11'h232, 11'h343};

  otp_ctrl_macro_arb #(.NumAgents(4), .MaxOutstanding(2)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .agent_req_i    (agent_req),
    .agent_cmd_i    (agent_cmd),
    .agent_size_i   (agent_size),
    .agent_wdata_i  (agent_wdata),
    .agent_addr_i   (agent_addr),
    .agent_gnt_o    (agent_gnt_o),
    .agent_rvalid_o (agent_rvalid_o),
    .agent_rdata_o  (agent_rdata_o),
    .agent_err_o    (agent_err_o),
    .otp_req_o      (otp_req_o),
    .otp_cmd_o      (otp_cmd_o),
    .otp_size_o     (otp_size_o),
    .otp_wdata_o    (otp_wdata_o),
    .otp_addr_o     (otp_addr_o),
    .otp_gnt_i      (otp_gnt),
    .otp_rvalid_i   (otp_rvalid),
    .otp_rdata_i    (otp_rdata),
    .otp_err_i      (otp_err),
    .arb_err_o      (arb_err_o),
    .idle_o         (idle_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic g, input logic rv, input logic [63:0] rd);
    @(posedge clk);
    #1;
    agent_req  = req;
    otp_gnt    = g;
    otp_rvalid = rv;
    otp_rdata  = rd;
  endtask

  task automatic exp_gnt(input int a);
    gq.push_back('{a, 64'(addr_tbl[a]), cyc});
  endtask

  task automatic exp_rv(input int a, input logic [63:0] d);
    rq.push_back('{a, d, cyc});
  endtask

  // Monitor: compares every presented grant / response against the queued expectation.
  initial begin : monitor
    exp_t       e;
    logic [3:0] oh;
    forever begin
      @(negedge clk);
      if (|agent_gnt_o) begin
        if (gq.size() == 0) begin
          chk("gnt_unexpected", 64'(agent_gnt_o), 64'd0);
        end else begin
          e = gq.pop_front();
          oh = 4'd0;
          oh[e.agent] = 1'b1;
          chk("gnt_onehot", 64'(agent_gnt_o), 64'(oh));
          chk("gnt_addr", 64'(otp_addr_o), e.data);
          chk("gnt_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
        e = gq.pop_front();
        oh = 4'd0;
        oh[e.agent] = 1'b1;
        chk("gnt_missing", 64'(agent_gnt_o), 64'(oh));
      end
      if (|agent_rvalid_o) begin
        if (rq.size() == 0) begin
          chk("rvalid_unexpected", 64'(agent_rvalid_o), 64'd0);
        end else begin
          e = rq.pop_front();
          oh = 4'd0;
          oh[e.agent] = 1'b1;
          chk("rvalid_onehot", 64'(agent_rvalid_o), 64'(oh));
          chk("rvalid_rdata", agent_rdata_o, e.data);
          chk("rvalid_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
        e = rq.pop_front();
        oh = 4'd0;
        oh[e.agent] = 1'b1;
        chk("rvalid_missing", 64'(agent_rvalid_o), 64'(oh));
      end
    end
  end

  initial begin : stim
    rst_ni     = 1'b0;
    agent_req  = 4'd0;
    otp_gnt    = 1'b0;
    otp_rvalid = 1'b0;
    otp_rdata  = 64'd0;
    otp_err    = 3'd0;
    for (int i = 0; i < 4; i++) begin
      agent_cmd[i]   = OtpCmdWidth'(i);
      agent_size[i]  = 2'd1;
      agent_wdata[i] = 16'h1000 + 16'(i);
      agent_addr[i]  = addr_tbl[i];
    end

    // Reset values
    @(negedge clk);
    chk("rst_idle", 64'(idle_o), 64'd1);
    chk("rst_req", 64'(otp_req_o), 64'd0);
    chk("rst_cmd", 64'(otp_cmd_o), 64'(Read));
    chk("rst_gnt", 64'(agent_gnt_o), 64'd0);
    chk("rst_err", 64'(arb_err_o), 64'd0);
    @(posedge clk);
    #1 rst_ni = 1'b1;

    // Agents 0 and 2 contend; response one cycle after each grant
    for (int k = 0; k < 4; k++) begin
      drive(4'b0101, 1'b1, (k > 0), 64'hA5A5);
      exp_gnt(Prio ? 0 : ((k % 2 == 0) ? 0 : 2));
      if (k > 0) exp_rv(Prio ? 0 : ((k % 2 == 1) ? 0 : 2), 64'hA5A5);
    end
    drive(4'b0000, 1'b0, 1'b1, 64'hA5A5);
    exp_rv(Prio ? 0 : 2, 64'hA5A5);
    drive(4'b0000, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    chk("idle_after_burst", 64'(idle_o), 64'd1);

    // Held request is not re-arbitrated when agent 0 joins
    drive(4'b0010, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    chk("hold_req", 64'(otp_req_o), 64'd1);
    chk("hold_addr_c1", 64'(otp_addr_o), 64'(addr_tbl[1]));
    for (int k = 2; k <= 3; k++) begin
      drive(4'b0011, 1'b0, 1'b0, 64'd0);
      @(negedge clk);
      chk("hold_addr", 64'(otp_addr_o), 64'(addr_tbl[1]));
    end
    drive(4'b0011, 1'b1, 1'b0, 64'd0);
    exp_gnt(1);
    drive(4'b0001, 1'b1, 1'b0, 64'd0);
    exp_gnt(0);

    // FIFO full (owners 1,0): agent 3 masked, pop does not unmask in the same cycle
    drive(4'b1000, 1'b1, 1'b0, 64'd0);
    @(negedge clk);
    chk("full_req_masked", 64'(otp_req_o), 64'd0);
    drive(4'b1000, 1'b1, 1'b1, 64'hDEAD_BEEF_0123_4567);
    exp_rv(1, 64'hDEAD_BEEF_0123_4567);
    @(negedge clk);
    chk("full_pop_same_cycle", 64'(otp_req_o), 64'd0);
    drive(4'b1000, 1'b1, 1'b0, 64'd0);
    exp_gnt(3);
    drive(4'b0000, 1'b0, 1'b1, 64'h0000_0000_0000_0042);
    exp_rv(0, 64'h42);
    drive(4'b0000, 1'b0, 1'b1, 64'hFFFF_0000_FFFF_0000);
    exp_rv(3, 64'hFFFF_0000_FFFF_0000);

    // Stray response with the FIFO empty
    drive(4'b0000, 1'b0, 1'b1, 64'h77);
    @(negedge clk);
    chk("stray_rvalid", 64'(agent_rvalid_o), 64'd0);
    chk("stray_err", 64'(arb_err_o), 64'd1);
    drive(4'b0000, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    chk("stray_err_pulse", 64'(arb_err_o), 64'd0);

    // Pointer at 3, agents 0 and 3 request
    drive(4'b0100, 1'b1, 1'b0, 64'd0);
    exp_gnt(2);
    drive(4'b1001, 1'b1, 1'b1, 64'h55);
    exp_rv(2, 64'h55);
    exp_gnt(Prio ? 0 : 3);
    drive(4'b0000, 1'b0, 1'b1, 64'h66);
    exp_rv(Prio ? 0 : 3, 64'h66);
    drive(4'b0000, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    chk("ptr_after_contest", 64'(dut.ptr_q), Prio ? 64'd1 : 64'd0);

    // Illegal state encoding -> terminal error state
    drive(4'b0001, 1'b0, 1'b0, 64'd0);
    force dut.state_q = arb_state_e'(5'b00000);
    @(negedge clk);
    chk("illegal_err", 64'(arb_err_o), 64'd1);
    chk("illegal_req", 64'(otp_req_o), 64'd0);
    drive(4'b0001, 1'b1, 1'b0, 64'd0);
    release dut.state_q;
    for (int k = 0; k < 3; k++) begin
      drive(4'b0001, 1'b1, 1'b1, 64'h99);
      @(negedge clk);
      chk("errst_err", 64'(arb_err_o), 64'd1);
      chk("errst_req", 64'(otp_req_o), 64'd0);
      chk("errst_rvalid", 64'(agent_rvalid_o), 64'd0);
    end

    // Reset recovers; arbitration restarts from pointer 0
    drive(4'b0000, 1'b0, 1'b0, 64'd0);
    rst_ni = 1'b0;
    @(negedge clk);
    chk("rerst_idle", 64'(idle_o), 64'd1);
    chk("rerst_err", 64'(arb_err_o), 64'd0);
    drive(4'b0000, 1'b0, 1'b0, 64'd0);
    rst_ni = 1'b1;
    drive(4'b0110, 1'b1, 1'b0, 64'd0);
    exp_gnt(1);
    drive(4'b0000, 1'b0, 1'b1, 64'h1234);
    exp_rv(1, 64'h1234);
    drive(4'b0000, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    chk("final_idle", 64'(idle_o), 64'd1);
    chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
    chk("rvalid_queue_drained", 64'(rq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/otp_ctrl_macro_arb.md
Name: otp_ctrl_macro_arb

Overview:
- Downstream stage of the life cycle interface, partitions and DAI: arbitrates their OTP macro command ports onto the single OTP macro interface.
- Routes each macro response (rvalid/rdata/err) back to the agent that issued the command.
- Round-robin grant; up to MaxOutstanding accepted commands tracked in order by an owner-ID FIFO.

Parameters:
- NumAgents, 4, number of requesting agents (>=2); agent 0 is the LCI by convention.
- MaxOutstanding, 2, maximum accepted-but-unanswered macro commands (>=1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset: asynchronous, active-low
- agent_req_i  in  NumAgents  per-agent command request
- agent_cmd_i  in  NumAgents x OtpCmdWidth  per-agent command (prim_otp_pkg::cmd_e)
- agent_size_i  in  NumAgents x OtpSizeWidth  per-agent size
- agent_wdata_i  in  NumAgents x OtpIfWidth  per-agent write data
- agent_addr_i  in  NumAgents x OtpAddrWidth  per-agent address
- agent_gnt_o  out  NumAgents  one-hot command accept
- agent_rvalid_o  out  NumAgents  one-hot response valid
- agent_rdata_o  out  ScrmblBlockWidth  broadcast response data
- agent_err_o  out  OtpErrWidth  broadcast response error code
- otp_req_o  out  1  macro request
- otp_cmd_o  out  OtpCmdWidth  macro command
- otp_size_o  out  OtpSizeWidth  macro size
- otp_wdata_o  out  OtpIfWidth  macro write data
- otp_addr_o  out  OtpAddrWidth  macro address
- otp_gnt_i  in  1  macro accept
- otp_rvalid_i  in  1  macro response valid
- otp_rdata_i  in  ScrmblBlockWidth  macro read data
- otp_err_i  in  OtpErrWidth  macro error code
- arb_err_o  out  1  pulse: response with no outstanding owner, or illegal FSM state
- idle_o  out  1  no request presented and no command outstanding

Behaviour:
- Reset values: all outputs 0, except idle_o=1 and otp_cmd_o=Read. Internal state after reset: pointer=0, FIFO empty, FSM ArbSt.
- FSM (sparse encoding, minimum Hamming distance 3): ArbSt, HoldSt, ErrorSt.
  - ArbSt: if FIFO not full and any agent_req_i is set, the winner is the first requester at or after the pointer (wraps NumAgents-1 -> 0). Its fields drive otp_*_o combinationally and otp_req_o=1 in the same cycle.
    - otp_gnt_i same cycle: agent_gnt_o[winner]=1, winner pushed to FIFO, pointer=winner+1 mod NumAgents.
    - No gnt: latch winner and go to HoldSt.
  - HoldSt: drive the latched winner only; no re-arbitration, even if higher-priority requests arrive. On otp_gnt_i: grant, push, update pointer, return to ArbSt. A requester dropping agent_req_i while held is a protocol violation (assertion); the latched request stays driven.
  - ErrorSt: terminal. otp_req_o=0, all gnt=0, responses are dropped, arb_err_o=1 every cycle. Entered on an illegal state encoding.
- FIFO full: otp_req_o=0 and no grant. Same-cycle pop does not unmask the request; the grant is delayed by one cycle.
- Response: on otp_rvalid_i with FIFO non-empty, agent_rvalid_o[head]=1 in the same cycle and the head is popped. rdata/err pass through combinationally.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - otp_rvalid_i with FIFO empty: no agent_rvalid_o, arb_err_o pulses for 1 cycle, FSM unchanged.
- Latency: 0 cycles request->macro, 0 cycles macro response->agent.
- Counter and pointer widths are vbits of their range; pointer and FIFO pointers wrap modulo their depth.
- Reset mid-transaction: FIFO and latch are cleared. Later responses hit the empty-FIFO error path.

Optional Feature:
- OTP_CTRL_ARB_AGENT0_PRIO_EN
  - Defined: agent 0 (LCI) wins whenever it requests in ArbSt, regardless of the pointer. The pointer still advances to 1 after an agent-0 grant.
  - Undefined: pure round-robin as above.

Decomposition:
- otp_ctrl_pkg: OtpCmdWidth, OtpErrWidth, the arb_state_e sparse encoding, and the agent index constant LciAgentIdx=0.
- One sub-module: otp_ctrl_owner_fifo, a synchronous FIFO of vbits(NumAgents)-bit IDs with full/empty/depth outputs.

Test Plan:
- Agents 0,2 request continuously, otp_gnt_i=1, rvalid 1 cycle after each gnt -> grants alternate 0,2,0,2; rvalid routed to the matching agent; rdata=0xA5A5 seen unchanged.
- Agent 1 requests, otp_gnt_i held 0 for 3 cycles, agent 0 requests in cycle 2 -> otp_addr_o stays agent 1's address; gnt goes to agent 1 on cycle 4; agent 0 granted next.
- MaxOutstanding=2, 2 grants with no rvalid, agent 3 requests -> otp_req_o=0; rvalid+pop in cycle N -> agent 3 granted in N+1, not N.
- otp_rvalid_i with empty FIFO -> all agent_rvalid_o=0, arb_err_o=1 for exactly 1 cycle.
- Force an illegal state encoding -> ErrorSt, arb_err_o stays 1, otp_req_o=0 until reset.
- With OTP_CTRL_ARB_AGENT0_PRIO_EN, pointer=3, agents 0 and 3 request -> agent 0 granted, pointer=1.
